bram_port_arbiter: RTL and testbench

- Shares the single external BRAM port of the pipelined processor between two requesters.
- The port is the 32-bit din/dout, the (LOGSIZE+3)-bit shared address and the per-byte write enables.
- Requester 0 is the host/AXI loader. Requester 1 is the matrix-multiply (MMM) DMA engine.
- Arbitration is round-robin with an optional burst lock. Read data from the 1-cycle-latency BRAM is routed back to the requester that issued the read.

---
 rtl/bram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for the shared processor BRAM port: round-robin with burst lock,
// read data steered back to its issuer. Optional macro ARB_LOCK_TIMEOUT_EN bounds lock length.
module bram_port_arbiter #(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 1024,
    parameter int NUM_COL  = 4,
    parameter int MAX_LOCK = 64,
    localparam int ADDR_W  = $clog2(SIZE) + 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               m0_req,
    input  logic               m0_lock,
    input  logic [ADDR_W-1:0]  m0_addr,
    input  logic [WIDTH-1:0]   m0_wdata,
    input  logic [NUM_COL-1:0] m0_wr_en,
    output logic               m0_gnt,
    output logic               m0_rvalid,
    output logic [WIDTH-1:0]   m0_rdata,
    input  logic               m1_req,
    input  logic               m1_lock,
    input  logic [ADDR_W-1:0]  m1_addr,
    input  logic [WIDTH-1:0]   m1_wdata,
    input  logic [NUM_COL-1:0] m1_wr_en,
    output logic               m1_gnt,
    output logic               m1_rvalid,
    output logic [WIDTH-1:0]   m1_rdata,
    output logic [ADDR_W-1:0]  shared_bram_addr,
    output logic [WIDTH-1:0]   bram_din,
    output logic [NUM_COL-1:0] bram_wr_en,
    input  logic [WIDTH-1:0]   bram_dout,
`ifdef ARB_LOCK_TIMEOUT_EN
    output logic               lock_timeout,
`endif
    output logic [1:0]         arb_state
);

    // Handshake: a transfer happens in exactly the cycles where mN_req && mN_gnt.
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t state, next_state;
    logic   last_grant, next_last_grant;
    logic   rd_pending, rd_owner;
    logic   acc0, acc1, rd_issue;

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    logic [CNT_W-1:0] lock_cnt;
    logic             lock_expired;
    assign lock_expired = (lock_cnt == CNT_W'(MAX_LOCK - 1));
`endif

    always_comb begin
        m0_gnt          = 1'b0;
        m1_gnt          = 1'b0;
        next_state      = state;
        next_last_grant = last_grant;
`ifdef ARB_LOCK_TIMEOUT_EN
        lock_timeout    = 1'b0;
`endif
        // Grants are masked while reset is held low.
        if (reset) begin
            case (state)
                IDLE: begin
                    if (m0_req && (!m1_req || last_grant)) begin
                        m0_gnt          = 1'b1;
                        next_last_grant = 1'b0;
                        next_state      = m0_lock ? OWN0 : IDLE;
                    end else if (m1_req) begin
                        m1_gnt          = 1'b1;
                        next_last_grant = 1'b1;
                        next_state      = m1_lock ? OWN1 : IDLE;
                    end
                end
                OWN0: begin
                    m0_gnt = 1'b1;
                    if (!m0_lock) begin
                        next_state = IDLE;
`ifdef ARB_LOCK_TIMEOUT_EN
                    end else if (lock_expired) begin
                        next_state   = IDLE;
                        lock_timeout = 1'b1;
`endif
                    end
                end
                OWN1: begin
                    m1_gnt = 1'b1;
                    if (!m1_lock) begin
                        next_state = IDLE;
`ifdef ARB_LOCK_TIMEOUT_EN
                    end else if (lock_expired) begin
                        next_state   = IDLE;
                        lock_timeout = 1'b1;
`endif
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign acc0     = m0_req && m0_gnt;
    assign acc1     = m1_req && m1_gnt;
    assign rd_issue = (acc0 && (m0_wr_en == '0)) || (acc1 && (m1_wr_en == '0));

    always_comb begin
        shared_bram_addr = '0;
        bram_din         = '0;
        bram_wr_en       = '0;
        if (acc0) begin
            shared_bram_addr = m0_addr;
            bram_din         = m0_wdata;
            bram_wr_en       = m0_wr_en;
        end else if (acc1) begin
            shared_bram_addr = m1_addr;
            bram_din         = m1_wdata;
            bram_wr_en       = m1_wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rd_pending <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            state      <= next_state;
            last_grant <= next_last_grant;
            rd_pending <= rd_issue;
            if (rd_issue) rd_owner <= acc1;
        end
    end

`ifdef ARB_LOCK_TIMEOUT_EN
    // Counts cycles spent in an owned state; restarts on every fresh entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_cnt <= '0;
        end else if (state != IDLE && next_state == state) begin
            lock_cnt <= lock_cnt + 1'b1;
        end else begin
            lock_cnt <= '0;
        end
    end
`endif

    // Response is masked during reset so a read in flight is dropped.
    assign m0_rvalid = reset && rd_pending && !rd_owner;
    assign m1_rvalid = reset && rd_pending && rd_owner;
    assign m0_rdata  = m0_rvalid ? bram_dout : '0;
    assign m1_rdata  = m1_rvalid ? bram_dout : '0;
    assign arb_state = state;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a small BRAM model and a read-response scoreboard.
module tb_bram_port_arbiter;

    localparam int WIDTH  = 32;
    localparam int NCOL   = 4;
    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic              m0_req, m0_lock, m1_req, m1_lock;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [WIDTH-1:0]  m0_wdata, m1_wdata;
    logic [NCOL-1:0]   m0_wr_en, m1_wr_en;
    logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [WIDTH-1:0]  m0_rdata, m1_rdata;
    logic [ADDR_W-1:0] shared_bram_addr;
    logic [WIDTH-1:0]  bram_din;
    logic [NCOL-1:0]   bram_wr_en;
    logic [WIDTH-1:0]  bram_dout = '0;
    logic [1:0]        arb_state;
`ifdef ARB_LOCK_TIMEOUT_EN
    logic              lock_timeout;
`endif

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];
    logic [31:0] mem [int];

    bram_port_arbiter #(.MAX_LOCK(4)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wr_en(m0_wr_en), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wr_en(m1_wr_en), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .shared_bram_addr(shared_bram_addr), .bram_din(bram_din), .bram_wr_en(bram_wr_en),
        .bram_dout(bram_dout),
`ifdef ARB_LOCK_TIMEOUT_EN
        .lock_timeout(lock_timeout),
`endif
        .arb_state(arb_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // BRAM model: unwritten words return an address-derived pattern
    function automatic logic [31:0] mem_rd(input logic [ADDR_W-1:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 32'h5A5A_0000 ^ {19'h0, a};
    endfunction

    always @(posedge clk) begin
        logic [31:0] w;
        if (bram_wr_en != '0) begin
            w = mem_rd(shared_bram_addr);
            for (int c = 0; c < NCOL; c++)
                if (bram_wr_en[c]) w[8*c +: 8] = bram_din[8*c +: 8];
            mem[int'(shared_bram_addr)] = w;
        end
        bram_dout <= mem_rd(shared_bram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drv0(input logic r, input logic l, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, input logic [NCOL-1:0] w);
        m0_req = r; m0_lock = l; m0_addr = a; m0_wdata = d; m0_wr_en = w;
    endtask

    task automatic drv1(input logic r, input logic l, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, input logic [NCOL-1:0] w);
        m1_req = r; m1_lock = l; m1_addr = a; m1_wdata = d; m1_wr_en = w;
    endtask

    // One cycle: check responses, grants and port against expectations, then advance.
    task automatic step(input logic g0, input logic g1);
        logic [32:0]       e;
        logic              e0v, e1v;
        logic [31:0]       e0d, e1d, ed;
        logic [ADDR_W-1:0] ea;
        logic [NCOL-1:0]   ew;
        #1;
        e0v = 1'b0; e1v = 1'b0; e0d = '0; e1d = '0;
        if (!reset) exp_q.delete();
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[32]) begin e1v = 1'b1; e1d = e[31:0]; end
            else       begin e0v = 1'b1; e0d = e[31:0]; end
        end
        chk("m0_rvalid", 32'(m0_rvalid), 32'(e0v));
        chk("m0_rdata",  m0_rdata, e0d);
        chk("m1_rvalid", 32'(m1_rvalid), 32'(e1v));
        chk("m1_rdata",  m1_rdata, e1d);
        chk("m0_gnt", 32'(m0_gnt), 32'(g0));
        chk("m1_gnt", 32'(m1_gnt), 32'(g1));
        ea = '0; ed = '0; ew = '0;
        if (g0 && m0_req) begin
            ea = m0_addr; ed = m0_wdata; ew = m0_wr_en;
            if (m0_wr_en == '0) exp_q.push_back({1'b0, mem_rd(m0_addr)});
        end else if (g1 && m1_req) begin
            ea = m1_addr; ed = m1_wdata; ew = m1_wr_en;
            if (m1_wr_en == '0) exp_q.push_back({1'b1, mem_rd(m1_addr)});
        end
        chk("bram_addr",  32'(shared_bram_addr), 32'(ea));
        chk("bram_din",   bram_din, ed);
        chk("bram_wr_en", 32'(bram_wr_en), 32'(ew));
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        drv0(1'b1, 1'b0, 13'h1000, '0, '0);
        drv1(1'b1, 1'b0, 13'h1004, '0, '0);
        mem[int'(13'h0010)] = 32'h1234_5678;
        @(negedge clk);
        // Reset held with both requesting: no grants
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        chk("state_after_reset", 32'(arb_state), 32'd0);
        reset = 1'b1;

        // Contention, lock=0: alternation starting with m0
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);

        // Write path from m1
        drv0(1'b0, 1'b0, '0, '0, '0);
        drv1(1'b1, 1'b0, 13'h1008, 32'hDEAD_BEEF, 4'b0011);
        step(1'b0, 1'b1);
        drv1(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0);

        // Burst lock: m0 holds the port for 8 reads while m1 waits
        drv1(1'b1, 1'b0, 13'h1008, '0, '0);
        for (int i = 0; i < 8; i++) begin
            drv0(1'b1, 1'b1, ADDR_W'(13'h0100 + 4*i), '0, '0);
            step(1'b1, 1'b0);
        end
        drv0(1'b0, 1'b1, 13'h0ABC, 32'h1111_2222, 4'b1111);
        step(1'b1, 1'b0);
        drv0(1'b1, 1'b0, 13'h0140, '0, '0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);

        // Read then switch: data returns to m0
        drv0(1'b1, 1'b0, 13'h0010, '0, '0);
        drv1(1'b1, 1'b0, 13'h1010, '0, '0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);

        // Reset asserted while a read is in flight: response dropped
        drv1(1'b0, 1'b0, '0, '0, '0);
        step(1'b1, 1'b0);
        drv0(1'b0, 1'b0, '0, '0, '0);
        reset = 1'b0;
        step(1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b0);

        // Randomised single-requester reads
        for (int i = 0; i < 4; i++) begin
            drv0(1'b1, 1'b0, ADDR_W'($urandom_range(0, 2047) * 4), '0, '0);
            step(1'b1, 1'b0);
        end
        drv0(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0);

`ifdef ARB_LOCK_TIMEOUT_EN
        // Timeout with MAX_LOCK=4: entry, four owned cycles, forced release, m1 next
        drv0(1'b1, 1'b1, 13'h0200, '0, '0);
        chk("lock_timeout_idle", 32'(lock_timeout), 32'd0);
        step(1'b1, 1'b0);
        drv1(1'b1, 1'b0, 13'h0300, '0, '0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("lock_timeout", 32'(lock_timeout), 32'(i == 3));
            step(1'b1, 1'b0);
        end
        #1;
        chk("lock_timeout_after", 32'(lock_timeout), 32'd0);
        step(1'b0, 1'b1);
        drv0(1'b0, 1'b0, '0, '0, '0);
        drv1(1'b0, 1'b0, '0, '0, '0);
        step(1'b0, 1'b0);
`endif

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
